// File: rtl/deadlock_trace_ctrl.sv
// deadlock_trace_ctrl: central sequencer for the per-process deadlock
// detect units of one dataflow region.
//
// It confirms a stable detection, picks one detecting process as trace
// origin, pulses that unit's origin input and follows the token around
// the dependence loop. It then clears the token and offers a report
// (origin id, loop member mask, timeout flag) over valid/ready.
//
// Ports:
//   clock, reset      clock; asynchronous active-low reset
//   dl_detect_vec     per-unit detect flags
//   proc_token_vec    per-process token presence
//   origin_vec        one-hot origin pulse to the units (registered)
//   token_clear       broadcast token clear (combinational)
//   dl_detect_any     analysis in progress, to every unit (registered)
//   report_valid      report available (registered)
//   report_ready      consumer accepts the report
//   report_origin     origin process id
//   report_mask       processes visited by the token, origin included
//   report_timeout    trace abandoned by timeout
//   rearm             leave HOLD and return to IDLE
//   busy              controller is not idle (combinational)
//
// Build option: define DEADLOCK_TRACE_CTRL_RR_EN for round-robin
// candidate selection; otherwise the lowest detecting index wins.

module deadlock_trace_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int ID_W           = 2,
    parameter int CONFIRM_CYCLES = 8,
    parameter int TRACE_TIMEOUT  = 256,
    parameter int CNT_W          = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] proc_token_vec,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                dl_detect_any,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [ID_W-1:0]     report_origin,
    output logic [PROC_NUM-1:0] report_mask,
    output logic                report_timeout,
    input  logic                rearm,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        CONFIRM,
        ORIGIN,
        TRACE,
        REPORT,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TRACE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     cand_q, cand_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROC_NUM-1:0] origin_d;
    logic                any_d;
    logic                valid_d;
    logic [ID_W-1:0]     rorig_d;
    logic [PROC_NUM-1:0] mask_d;
    logic                tmo_d;

    logic [ID_W-1:0]     pick;
    logic [PROC_NUM-1:0] cand_hot;
    logic                tok_ret;
    logic                tok_tmo;

    assign cand_hot = PROC_NUM'(1) << cand_q;

    // Token back at the origin only counts after it has left, i.e. not
    // in the first trace cycle.
    assign tok_ret = proc_token_vec[cand_q] && (cnt_q != '0);
    assign tok_tmo = (cnt_q == TMO_LAST);

    assign busy = (state_q != IDLE);

`ifdef DEADLOCK_TRACE_CTRL_RR_EN

    logic [ID_W-1:0] last_origin_q;
    logic            last_vld_q;

    // Search starts one past the previous origin; before any origin has
    // been issued it starts at index 0.
    always_comb begin
        int  start;
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        start = 0;
        idx   = 0;
        if (last_vld_q) begin
            start = (int'(last_origin_q) + 1) % PROC_NUM;
        end
        for (int k = 0; k < PROC_NUM; k++) begin
            idx = (start + k) % PROC_NUM;
            if (!found && dl_detect_vec[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_origin_q <= '0;
            last_vld_q    <= 1'b0;
        end else if (state_q == ORIGIN) begin
            last_origin_q <= cand_q;
            last_vld_q    <= 1'b1;
        end
    end

`else

    // Fixed priority: scanning downwards leaves the lowest set index.
    always_comb begin
        pick = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_detect_vec[i]) begin
                pick = ID_W'(i);
            end
        end
    end

`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cand_q         <= '0;
            cnt_q          <= '0;
            origin_vec     <= '0;
            dl_detect_any  <= 1'b0;
            report_valid   <= 1'b0;
            report_origin  <= '0;
            report_mask    <= '0;
            report_timeout <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            origin_vec     <= origin_d;
            dl_detect_any  <= any_d;
            report_valid   <= valid_d;
            report_origin  <= rorig_d;
            report_mask    <= mask_d;
            report_timeout <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        origin_d    = '0;
        any_d       = dl_detect_any;
        valid_d     = report_valid;
        rorig_d     = report_origin;
        mask_d      = report_mask;
        tmo_d       = report_timeout;
        token_clear = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|dl_detect_vec) begin
                    cand_d  = pick;
                    cnt_d   = '0;
                    state_d = CONFIRM;
                end
            end

            CONFIRM: begin
                // Only the chosen candidate matters; a drop is a glitch.
                if (!dl_detect_vec[cand_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == CONF_LAST) begin
                    // origin_vec is registered, so load it on entry to
                    // ORIGIN to have it high during that single cycle.
                    origin_d = cand_hot;
                    any_d    = 1'b1;
                    state_d  = ORIGIN;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ORIGIN: begin
                mask_d  = cand_hot;
                cnt_d   = '0;
                state_d = TRACE;
            end

            TRACE: begin
                mask_d = report_mask | proc_token_vec;
                cnt_d  = cnt_q + CNT_ONE;
                if (tok_ret || tok_tmo) begin
                    token_clear = 1'b1;
                    tmo_d       = !tok_ret;
                    valid_d     = 1'b1;
                    rorig_d     = cand_q;
                    state_d     = REPORT;
                end
            end

            REPORT: begin
                if (report_ready) begin
                    valid_d = 1'b0;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (rearm) begin
                    any_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_deadlock_trace_ctrl.sv
// tb_deadlock_trace_ctrl: scoreboard bench for deadlock_trace_ctrl.
// Expected reports are queued when a trace is driven to its end.

module tb_deadlock_trace_ctrl;

    localparam int PN   = 4;
    localparam int CONF = 8;
    localparam int TMO  = 16;

`ifdef DEADLOCK_TRACE_CTRL_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] origin;
        logic [3:0] mask;
        logic       timeout;
    } rpt_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic [3:0] proc_token_vec;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       dl_detect_any;
    logic       report_valid;
    logic       report_ready;
    logic [1:0] report_origin;
    logic [3:0] report_mask;
    logic       report_timeout;
    logic       rearm;
    logic       busy;

    rpt_t       sb[$];
    rpt_t       pend;
    rpt_t       got_e;
    logic [3:0] tk[16];
    int         checks = 0;
    int         errors = 0;
    int         last_o;
    bit         last_v;
    int         cand;

    deadlock_trace_ctrl #(
        .PROC_NUM(PN),
        .ID_W(2),
        .CONFIRM_CYCLES(CONF),
        .TRACE_TIMEOUT(TMO),
        .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dl_detect_vec(dl_detect_vec),
        .proc_token_vec(proc_token_vec),
        .origin_vec(origin_vec),
        .token_clear(token_clear),
        .dl_detect_any(dl_detect_any),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_origin(report_origin),
        .report_mask(report_mask),
        .report_timeout(report_timeout),
        .rearm(rearm),
        .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_cand(input logic [3:0] vec);
        int start;
        start = 0;
        if (RR_EN && last_v) start = (last_o + 1) % PN;
        for (int k = 0; k < PN; k++) begin
            if (vec[(start + k) % PN]) return (start + k) % PN;
        end
        return 0;
    endfunction

    // Scoreboard: pop on every accepted report.
    always @(negedge clock) begin
        if (reset === 1'b1 && report_valid && report_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                got_e = sb.pop_front();
                check("sb_origin", report_origin, got_e.origin);
                check("sb_mask", report_mask, got_e.mask);
                check("sb_timeout", report_timeout, got_e.timeout);
            end
        end
    end

    task automatic run_confirm(input logic [3:0] vec, output int c_out);
        int seen;
        seen  = -1;
        c_out = exp_cand(vec);
        @(posedge clock); #1;
        dl_detect_vec = vec;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (origin_vec != 4'b0) begin
                seen = c;
                break;
            end
            check("cf_busy", busy, c >= 1);
            check("cf_any", dl_detect_any, 0);
            @(posedge clock); #1;
        end
        check("cf_latency", seen, CONF + 1);
        check("cf_origin", origin_vec, 32'(1) << c_out);
        check("cf_any_set", dl_detect_any, 1);
        last_o = c_out;
        last_v = 1'b1;
    endtask

    task automatic run_trace(input int c_in);
        logic [3:0] mask;
        bit ret;
        bit done;
        mask = 4'(32'(1) << c_in);
        done = 1'b0;
        for (int t = 0; t < TMO && !done; t++) begin
            @(posedge clock); #1;
            proc_token_vec = tk[t];
            mask = mask | tk[t];
            ret  = tk[t][c_in] && (t >= 1);
            done = ret || (t == TMO - 1);
            if (done) begin
                pend.origin  = 2'(c_in);
                pend.mask    = mask;
                pend.timeout = !ret;
                sb.push_back(pend);
            end
            @(negedge clock);
            check("tr_clear", token_clear, done);
            check("tr_origin_low", origin_vec, 0);
        end
        @(posedge clock); #1;
        proc_token_vec = 4'b0;
        @(negedge clock);
        check("rp_valid", report_valid, 1);
    endtask

    task automatic handshake(input int stall);
        for (int s = 0; s < stall; s++) begin
            @(posedge clock); #1;
            @(negedge clock);
            check("hs_valid", report_valid, 1);
            check("hs_origin", report_origin, pend.origin);
            check("hs_mask", report_mask, pend.mask);
            check("hs_timeout", report_timeout, pend.timeout);
        end
        @(posedge clock); #1;
        report_ready = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        report_ready = 1'b0;
        @(negedge clock);
        check("hold_valid", report_valid, 0);
        check("hold_busy", busy, 1);
        check("hold_any", dl_detect_any, 1);
    endtask

    task automatic rearm_seq();
        @(posedge clock); #1;
        dl_detect_vec = 4'b0;
        rearm = 1'b1;
        @(negedge clock);
        check("rearm_any_pre", dl_detect_any, 1);
        @(posedge clock); #1;
        rearm = 1'b0;
        @(negedge clock);
        check("rearm_any", dl_detect_any, 0);
        check("rearm_busy", busy, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b0;
        dl_detect_vec  = 4'b0;
        proc_token_vec = 4'b0;
        report_ready   = 1'b0;
        rearm          = 1'b0;
        last_o         = 0;
        last_v         = 1'b0;
        foreach (tk[i]) tk[i] = 4'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_origin", origin_vec, 0);
        check("rst_any", dl_detect_any, 0);
        check("rst_valid", report_valid, 0);
        check("rst_mask", report_mask, 0);
        check("rst_clear", token_clear, 0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Glitch: candidate 1 drops after three cycles.
        @(posedge clock); #1;
        dl_detect_vec = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("gl_busy", busy, (c >= 1) && (c <= 3));
            check("gl_origin", origin_vec, 0);
            check("gl_any", dl_detect_any, 0);
            @(posedge clock); #1;
            if (c == 2) dl_detect_vec = 4'b0;
        end

        // Token loop from process 2.
        run_confirm(4'b0100, cand);
        check("a_cand", cand, 2);
        foreach (tk[i]) tk[i] = 4'b0;
        tk[0] = 4'b0001;
        tk[1] = 4'b1000;
        tk[2] = 4'b0100;
        run_trace(cand);
        check("a_origin", report_origin, 2);
        check("a_mask", report_mask, 4'b1101);
        check("a_timeout", report_timeout, 0);
        handshake(5);
        rearm_seq();

        // Priority, early-return ignored, return wins over timeout.
        run_confirm(4'b0110, cand);
        foreach (tk[i]) tk[i] = 4'b0;
        tk[0]  = 4'(32'(1) << cand);
        tk[15] = 4'(32'(1) << cand) | 4'b0001;
        run_trace(cand);
        check("b_timeout", report_timeout, 0);
        handshake(1);
        rearm_seq();

        // Timeout on process 2.
        run_confirm(4'b0100, cand);
        foreach (tk[i]) tk[i] = 4'b0;
        run_trace(cand);
        check("c_timeout", report_timeout, 1);
        check("c_mask", report_mask, 4'b0100);
        handshake(0);
        rearm_seq();

        // Reset in the middle of a trace.
        run_confirm(4'b0010, cand);
        @(posedge clock); #1;
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        check("mr_origin", origin_vec, 0);
        check("mr_clear", token_clear, 0);
        check("mr_any", dl_detect_any, 0);
        check("mr_valid", report_valid, 0);
        check("mr_rorig", report_origin, 0);
        check("mr_mask", report_mask, 0);
        check("mr_timeout", report_timeout, 0);
        check("mr_busy", busy, 0);
        last_v = 1'b0;
        dl_detect_vec = 4'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("mr_idle_busy", busy, 0);
            check("mr_idle_origin", origin_vec, 0);
            @(posedge clock); #1;
        end

        // Fresh run after reset; token returns at the earliest cycle.
        run_confirm(4'b0001, cand);
        foreach (tk[i]) tk[i] = 4'b0;
        tk[0] = 4'b0010;
        tk[1] = 4'b0001;
        run_trace(cand);
        check("e_mask", report_mask, 4'b0011);
        check("e_timeout", report_timeout, 0);
        handshake(0);
        rearm_seq();

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/deadlock_trace_ctrl.md
Name: deadlock_trace_ctrl

Overview:
- Central sequencer for the per-process deadlock detect units of one HLS dataflow region.
- Watches every unit's detect flag and confirms that a detection is stable.
- Picks one detecting process as trace origin, pulses its origin input and follows the token around the dependence loop.
- Clears the token, then presents a report (origin id, set of processes in the loop, timeout flag) with a valid/ready handshake.

Parameters:
- PROC_NUM, 4, number of processes/detect units.
- ID_W, 2, width of process id; must be >= clog2(PROC_NUM).
- CONFIRM_CYCLES, 8, consecutive cycles a candidate's detect flag must stay high before tracing starts (>=1).
- TRACE_TIMEOUT, 256, maximum number of TRACE cycles before the trace is abandoned (>=2).
- CNT_W, 16, width of the shared cycle counter; must hold max(CONFIRM_CYCLES, TRACE_TIMEOUT).

Ports:
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- dl_detect_vec  in  PROC_NUM  bit i = dl_detect_out of unit i.
- proc_token_vec  in  PROC_NUM  bit i = OR of unit i's token_in_vec (process i holds the token this cycle).
- origin_vec  out  PROC_NUM  one-hot origin pulse to the units.
- token_clear  out  1  broadcast token clear.
- dl_detect_any  out  1  broadcast to every unit's dl_detect_in; marks that analysis is in progress.
- report_valid  out  1  report available.
- report_ready  in  1  consumer accepts the report.
- report_origin  out  ID_W  id of the origin process.
- report_mask  out  PROC_NUM  processes visited by the token, origin included.
- report_timeout  out  1  trace ended by timeout, not by the token returning.
- rearm  in  1  leave HOLD and return to IDLE.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE. origin_vec, token_clear, dl_detect_any, report_valid, report_origin, report_mask, report_timeout, busy, cand and cnt all 0. Reset asserted in any state forces this immediately, because it is asynchronous.
- All outputs are registered except token_clear and busy, which are decoded from state and inputs.
- IDLE:
  - If |dl_detect_vec, set cand = lowest set index, clear cnt and go to CONFIRM. Otherwise stay.
- CONFIRM:
  - If dl_detect_vec[cand]==0, go to IDLE. This is glitch rejection; other bits are ignored.
  - Else if cnt==CONFIRM_CYCLES-1, go to ORIGIN and set dl_detect_any=1.
  - Else cnt++.
- ORIGIN (exactly one cycle):
  - origin_vec = 1<<cand.
  - report_mask <= 1<<cand; cnt <= 0; go to TRACE.
- TRACE:
  - origin_vec=0. Each cycle report_mask |= proc_token_vec and cnt++.
  - If proc_token_vec[cand]==1 and cnt>=1: token_clear=1 this cycle, report_timeout<=0, go to REPORT.
  - Else if cnt==TRACE_TIMEOUT-1: token_clear=1 this cycle, report_timeout<=1, go to REPORT.
  - If both hold on the same cycle, token return wins.
- REPORT:
  - report_valid=1. report_origin=cand. report_mask and report_timeout are held stable.
  - On report_valid & report_ready, report_valid<=0 and go to HOLD.
  - rearm is ignored.
- HOLD:
  - dl_detect_any stays 1; dl_detect_vec is ignored.
  - On rearm, go to IDLE and dl_detect_any<=0 on the same edge. report fields retain their values until the next ORIGIN.
- busy=1 in every state except IDLE.
- Arithmetic: cnt wraps only across state changes. No operand is wider than CNT_W.
- Candidate selection applies only in IDLE. cand is frozen from CONFIRM through HOLD.

Optional Feature:
- Macro: DEADLOCK_TRACE_CTRL_RR_EN.
- Defined: IDLE candidate selection is round-robin. The search starts at (last_origin+1) mod PROC_NUM, where last_origin is the register updated in ORIGIN (reset 0 and search starts at index 0, i.e. last_origin is treated as PROC_NUM-1 after reset).
- Undefined: fixed lowest-index priority, and no last_origin register exists.

Test Plan:
1. Confirm and origin:
   - Stimulus: dl_detect_vec=4'b0100 from cycle 0 onward, CONFIRM_CYCLES=8.
   - Response: busy=1 from cycle 1. origin_vec=4'b0100 for exactly one cycle at cycle 9. dl_detect_any=1 from cycle 9.
2. Glitch rejection:
   - Stimulus: dl_detect_vec=4'b0010 for 3 cycles, then 0.
   - Response: no origin pulse, dl_detect_any stays 0, busy returns to 0 one cycle after the drop.
3. Token loop:
   - Stimulus: after origin on proc 2, proc_token_vec = 0001, 1000, 0100 on consecutive cycles.
   - Response: token_clear high exactly in the 0100 cycle. Next cycle report_valid=1, report_origin=2, report_mask=4'b1101, report_timeout=0.
4. Timeout:
   - Stimulus: TRACE_TIMEOUT=16, proc_token_vec held 0 after origin.
   - Response: token_clear pulses on the 16th TRACE cycle. report_timeout=1, report_mask=4'b0100.
5. Handshake, rearm and priority:
   - Stimulus: report_ready low for 5 cycles, then high. Then pulse rearm. Then drive dl_detect_vec=4'b0110.
   - Response: report_valid and fields stable for all 5 stalled cycles. dl_detect_any drops after rearm. cand=1 without the macro; with the macro and last_origin=1, cand=2.
6. Reset mid-trace:
   - Stimulus: drop reset during TRACE.
   - Response: all outputs 0 immediately. After reset release, state is IDLE and no origin pulse occurs until a new confirm completes.
